// File: rtl/out_uart_tx.sv
// Reports the 16-bit out value over UART as "HHHH\r\n" (8N1, DIVISOR clks/bit) whenever it differs from the last value sent.
// Start bit 1 cycle after the triggering edge; changes seen while busy are coalesced and flagged on ovf.
module out_uart_tx #(
  parameter int DIVISOR = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] out,
  output logic        txd,
  output logic        busy,
  output logic        ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);

  logic [1:0]  state;
  logic [15:0] last;
  logic [15:0] out_q;
  logic [15:0] baud_cnt;
  logic [2:0]  char_idx;
  logic [2:0]  bit_idx;
  logic [2:0]  next_bit;
  logic [7:0]  cur_char;
  logic        baud_tick;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      3'd0:    cur_char = hex_ascii(last[15:12]);
      3'd1:    cur_char = hex_ascii(last[11:8]);
      3'd2:    cur_char = hex_ascii(last[7:4]);
      3'd3:    cur_char = hex_ascii(last[3:0]);
      3'd4:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  assign baud_tick = (baud_cnt == DIV_LAST);
  assign next_bit  = bit_idx + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 16'h0000;
      out_q    <= 16'h0000;
      baud_cnt <= 16'h0000;
      char_idx <= 3'd0;
      bit_idx  <= 3'd0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      out_q <= out;
      ovf   <= busy && (out != out_q);
      // The counter restarts at every bit boundary, so bit periods never drift.
      if (state != IDLE) baud_cnt <= baud_tick ? 16'h0000 : baud_cnt + 16'h0001;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (out != last) begin
            last     <= out;
            busy     <= 1'b1;
            state    <= START;
            txd      <= 1'b0;
            baud_cnt <= 16'h0000;
            char_idx <= 3'd0;
            bit_idx  <= 3'd0;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            txd     <= cur_char[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= next_bit;
              txd     <= cur_char[next_bit];
            end
          end
        end
        default: begin
          if (baud_tick) begin
            if (char_idx == 3'd5) begin
              state <= IDLE;
              busy  <= 1'b0;
              txd   <= 1'b1;
            end else begin
              char_idx <= char_idx + 3'd1;
              state    <= START;
              txd      <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx at DIVISOR=4: stimulus queues expected bytes, a UART monitor decodes txd and compares.
module tb_out_uart_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] out;
  logic        txd;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_cyc[$];

  out_uart_tx #(.DIVISOR(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .out   (out),
    .txd   (txd),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push6(input logic [47:0] v);
    for (int i = 5; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  // UART monitor: 4 samples per bit, 40 per character
  initial begin
    logic [39:0] s;
    logic [7:0]  data;
    logic [7:0]  expb;
    int          bad;
    bit          aborted;
    forever begin
      @(posedge clk); #1;
      if (rst_n && txd == 1'b0) begin
        start_cyc.push_back(cyc);
        s = '1;
        s[0] = txd;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(posedge clk); #1;
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          s[i] = txd;
        end
        if (!aborted) begin
          bad = 0;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < 4; j++)
              if (s[k*4+j] !== s[k*4]) bad++;
          if (s[36] !== 1'b1) bad++;
          for (int b = 0; b < 8; b++) data[b] = s[(b+1)*4];
          check("char_framing", bad, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL char_unexpected: got 0x%02h, expected no character", data);
          end else begin
            expb = exp_q.pop_front();
            check("char_value", data, expb);
          end
        end
      end
    end
  end

  // Waits for a frame launched from the preceding negedge and measures busy width.
  task automatic run_frame(input string name);
    int t, hi, first, txd_first;
    t = 0; hi = 0; first = 0; txd_first = 1;
    do begin
      @(posedge clk); #1;
      t++;
      if (busy) begin
        if (hi == 0) begin
          first = t;
          txd_first = int'(txd);
        end
        hi++;
      end
    end while ((hi == 0 || busy) && t < 2000);
    check({name, "_start_latency"}, first, 1);
    check({name, "_start_bit"}, txd_first, 0);
    check({name, "_busy_cycles"}, hi, 240);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_spacing(input string name);
    int bad;
    bad = 0;
    for (int i = 1; i < start_cyc.size(); i++)
      if (start_cyc[i] - start_cyc[i-1] != 40) bad++;
    check({name, "_char_count"}, start_cyc.size(), 6);
    check({name, "_char_spacing"}, bad, 0);
    start_cyc.delete();
  endtask

  initial begin
    int n_txd0, n_busy, n_ovf, ovf_cnt, busy_fall, restart;
    bit ovf50, ovf100;

    rst_n = 1'b0;
    out   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Quiet after reset with out at zero
    n_txd0 = 0; n_busy = 0; n_ovf = 0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (!txd) n_txd0++;
      if (busy) n_busy++;
      if (ovf) n_ovf++;
    end
    check("idle_txd_low_cycles", n_txd0, 0);
    check("idle_busy_cycles", n_busy, 0);
    check("idle_ovf_pulses", n_ovf, 0);

    // "12AB\r\n"
    start_cyc.delete();
    @(negedge clk);
    out = 16'h12AB;
    push6(48'h3132_4142_0D0A);
    run_frame("f12ab");
    check_spacing("f12ab");

    // "FFFF" with changes at cycles 50 and 100; only BEEF is reported next
    push6(48'h4646_4646_0D0A);
    push6(48'h4245_4546_0D0A);
    ovf_cnt = 0; ovf50 = 0; ovf100 = 0; busy_fall = -1; restart = -1;
    @(negedge clk);
    out = 16'hFFFF;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (ovf) ovf_cnt++;
      if (k == 50) ovf50 = ovf;
      if (k == 100) ovf100 = ovf;
      if (k > 0 && !busy && busy_fall < 0) busy_fall = k;
      if (busy_fall >= 0 && k > busy_fall && !txd && restart < 0) restart = k;
      @(negedge clk);
      if (k == 49) out = 16'hF00D;
      if (k == 99) out = 16'hBEEF;
    end
    check("ovf_at_50", ovf50, 1'b1);
    check("ovf_at_100", ovf100, 1'b1);
    check("ovf_pulse_count", ovf_cnt, 2);
    check("ffff_busy_fall", busy_fall, 240);
    check("beef_restart", restart, 241);
    check("beef_done_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    start_cyc.delete();

    // Reset mid-character aborts; a fresh "00C0" follows release
    @(negedge clk);
    out = 16'h00C0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    start_cyc.delete();
    push6(48'h3030_4330_0D0A);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("f00c0");
    check_spacing("f00c0");

    // 0001 then back to 0000
    @(negedge clk);
    out = 16'h0001;
    push6(48'h3030_3031_0D0A);
    run_frame("f0001");
    check_spacing("f0001");
    @(negedge clk);
    out = 16'h0000;
    push6(48'h3030_3030_0D0A);
    run_frame("f0000");
    check_spacing("f0000");

    repeat (20) @(posedge clk);
    check("scoreboard_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
